// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the playfield RAM between the display fetch path (priority)
// and the game-logic port, with a starvation counter forcing game grants through.
module board_ram_arbiter #(
    parameter int ROWS       = 20,
    parameter int COLS       = 10,
    parameter int CW         = 3,
    parameter int AW         = 8,
    parameter int STARVE_MAX = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_disp_req,
    input  logic [4:0]    i_disp_row,
    input  logic [3:0]    i_disp_col,
    output logic          o_disp_valid,
    output logic [CW-1:0] o_disp_color,
    output logic          o_disp_miss,
    input  logic          i_g_req,
    input  logic          i_g_we,
    input  logic [4:0]    i_g_row,
    input  logic [3:0]    i_g_col,
    input  logic [CW-1:0] i_g_wdata,
    output logic          o_g_ack,
    output logic [CW-1:0] o_g_rdata,
    output logic [AW-1:0] o_ram_addr,
    output logic          o_ram_we,
    output logic [CW-1:0] o_ram_wdata,
    input  logic [CW-1:0] i_ram_rdata
);
    localparam int WW = $clog2(STARVE_MAX + 1);
    typedef enum logic [1:0] {G_IDLE, G_ISSUED, G_RESP} g_state_t;
    typedef struct packed {
        logic dv;
        logic dmiss;
        logic door;
        logic gv;
        logic gwe;
        logic goor;
    } slot_t;
    g_state_t      r_g_state;
    logic [WW-1:0] r_wait;
    slot_t         r_p1, r_p2, w_p0;
    logic          w_g_idle, w_g_win, w_d_win, w_d_oor, w_g_oor;
    logic [AW-1:0] w_d_addr, w_g_addr;
    assign w_d_oor  = 32'(i_disp_row) >= ROWS || 32'(i_disp_col) >= COLS;
    assign w_g_oor  = 32'(i_g_row) >= ROWS || 32'(i_g_col) >= COLS;
    assign w_d_addr = AW'(32'(i_disp_row) * COLS + 32'(i_disp_col));
    assign w_g_addr = AW'(32'(i_g_row) * COLS + 32'(i_g_col));
    assign w_g_idle = r_g_state == G_IDLE;
    assign w_g_win  = i_g_req && w_g_idle && (!i_disp_req || 32'(r_wait) >= STARVE_MAX);
    assign w_d_win  = i_disp_req && !w_g_win;
    // A display request that loses to a forced game grant still produces a (miss) response.
    assign w_p0 = '{dv: i_disp_req, dmiss: i_disp_req && w_g_win, door: w_d_oor,
                    gv: w_g_win, gwe: i_g_we, goor: w_g_oor};
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_g_state    <= G_IDLE;
            r_wait       <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            o_ram_addr   <= '0;
            o_ram_we     <= 1'b0;
            o_ram_wdata  <= '0;
            o_disp_valid <= 1'b0;
            o_disp_color <= '0;
            o_disp_miss  <= 1'b0;
            o_g_ack      <= 1'b0;
            o_g_rdata    <= '0;
        end else begin
            r_p1     <= w_p0;
            r_p2     <= r_p1;
            o_ram_we <= w_g_win && i_g_we && !w_g_oor;
            if (w_g_win && !w_g_oor) begin
                o_ram_addr  <= w_g_addr;
                o_ram_wdata <= i_g_wdata;
            end else if (w_d_win && !w_d_oor) begin
                o_ram_addr <= w_d_addr;
            end
            r_wait <= (!i_g_req || w_g_win) ? '0 :
                      (w_g_idle && i_disp_req && 32'(r_wait) < STARVE_MAX) ? r_wait + 1'b1 : r_wait;
            r_g_state <= w_g_idle ? (w_g_win ? G_ISSUED : G_IDLE) :
                         r_g_state == G_ISSUED ? G_RESP : G_IDLE;
            // Responses land two edges after the grant, once the synchronous RAM has answered.
            o_disp_valid <= r_p2.dv;
            o_disp_miss  <= r_p2.dmiss;
            if (r_p2.dv && !r_p2.dmiss)
                o_disp_color <= r_p2.door ? '0 : i_ram_rdata;
            o_g_ack <= r_p2.gv;
            if (r_p2.gv)
                o_g_rdata <= (r_p2.gwe || r_p2.goor) ? '0 : i_ram_rdata;
        end
    end
endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb_board_ram_arbiter: directed and randomized scoreboard bench; a transaction-level model
// predicts every response and RAM command, a negedge monitor checks what the DUT presents.
module tb_board_ram_arbiter;
    localparam int ROWS = 20, COLS = 10, CW = 3, AW = 8, STARVE_MAX = 8;

    logic clk = 1'b0, rst = 1'b1;
    logic dreq = 1'b0, greq = 1'b0, gwe = 1'b0;
    logic [4:0] drow = '0, grow = '0;
    logic [3:0] dcol = '0, gcol = '0;
    logic [CW-1:0] gwd = '0;
    logic dvalid, dmiss_o, gack, ram_we;
    logic [CW-1:0] dcolor, grdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic pl_we = 1'b0;
    logic [AW-1:0] pl_a = '0;
    logic [CW-1:0] pl_d = '0;

    board_ram_arbiter #(.ROWS(ROWS), .COLS(COLS), .CW(CW), .AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_disp_req(dreq), .i_disp_row(drow), .i_disp_col(dcol),
        .o_disp_valid(dvalid), .o_disp_color(dcolor), .o_disp_miss(dmiss_o),
        .i_g_req(greq), .i_g_we(gwe), .i_g_row(grow), .i_g_col(gcol), .i_g_wdata(gwd),
        .o_g_ack(gack), .o_g_rdata(grdata),
        .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Board RAM: synchronous single port, read-first, with a bench-only preload port.
    logic [CW-1:0] ram [256];
    always @(posedge clk) begin
        if (pl_we) ram[pl_a] <= pl_d;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    typedef struct {int due; logic [CW-1:0] data; logic miss;} rsp_t;
    typedef struct {int e; logic we; logic chka; logic [AW-1:0] addr; logic [CW-1:0] wd;} ram_t;
    rsp_t dq[$], gq[$];
    ram_t rq[$];
    logic [CW-1:0] shadow [ROWS*COLS];
    logic [CW-1:0] last_color = '0, undo_old = '0, gi_wd = '0;
    int wait_n = 0, g_free = 0, g_done = 0, undo_e = 0, undo_cell = 0, g_rep = 0, gi_rep = 0;
    logic g_granted = 1'b0, gi_pend = 1'b0, gi_we = 1'b0;
    logic [4:0] gi_row = '0;
    logic [3:0] gi_col = '0;
    int vectors = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Spec-level model: decides the winner of the coming edge and queues what must follow.
    task automatic apply(input logic d, input int dr, input int dc);
        int g, gc, dcell;
        logic idle, gw, goor, door;
        if (g_granted && edge_n >= g_done) begin
            g_granted = 1'b0;
            if (g_rep > 0) g_rep--;
            else greq = 1'b0;
        end
        if (!greq && gi_pend) begin
            greq = 1'b1; gwe = gi_we; grow = gi_row; gcol = gi_col; gwd = gi_wd;
            g_rep = gi_rep; gi_pend = 1'b0;
        end
        dreq = d; drow = 5'(dr); dcol = 4'(dc);
        g = edge_n + 1;
        idle = g >= g_free;
        gw = greq && idle && (!d || wait_n >= STARVE_MAX);
        goor = !(int'(grow) < ROWS && int'(gcol) < COLS);
        door = !(dr < ROWS && dc < COLS);
        gc = int'(grow) * COLS + int'(gcol);
        dcell = dr * COLS + dc;
        if (gw) begin
            if (gwe || goor) gq.push_back('{g + 2, '0, 1'b0});
            else gq.push_back('{g + 2, shadow[gc], 1'b0});
            if (gwe && !goor) begin
                undo_e = g + 1; undo_cell = gc; undo_old = shadow[gc]; shadow[gc] = gwd;
            end
            rq.push_back('{g, gwe && !goor, !goor, AW'(gc), gwd});
            g_free = g + 3; g_done = g + 2; g_granted = 1'b1;
        end else if (d && !door) rq.push_back('{g, 1'b0, 1'b1, AW'(dcell), '0});
        else rq.push_back('{g, 1'b0, 1'b0, '0, '0});
        if (d) begin
            if (gw) dq.push_back('{g + 2, last_color, 1'b1});
            else begin
                last_color = door ? '0 : shadow[dcell];
                dq.push_back('{g + 2, last_color, 1'b0});
            end
        end
        wait_n = (!greq || gw) ? 0 : (idle && d && wait_n < STARVE_MAX) ? wait_n + 1 : wait_n;
    endtask

    task automatic tick(input logic d, input int dr, input int dc);
        @(posedge clk); #1;
        apply(d, dr, dc);
    endtask

    task automatic game_start(input logic we, input int r, input int c, input int wd, input int rep);
        gi_pend = 1'b1; gi_we = we; gi_row = 5'(r); gi_col = 4'(c); gi_wd = CW'(wd); gi_rep = rep;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60 && (greq || gi_pend || dq.size() > 0 || gq.size() > 0); n++)
            tick(1'b0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " disp_valid"}, int'(dvalid), 0);
        chk({tag, " disp_color"}, int'(dcolor), 0);
        chk({tag, " disp_miss"}, int'(dmiss_o), 0);
        chk({tag, " g_ack"}, int'(gack), 0);
        chk({tag, " g_rdata"}, int'(grdata), 0);
        chk({tag, " ram_addr"}, int'(ram_addr), 0);
        chk({tag, " ram_we"}, int'(ram_we), 0);
        chk({tag, " ram_wdata"}, int'(ram_wdata), 0);
    endtask

    task automatic reset_mid();
        @(posedge clk); #1;
        rst = 1'b1; dreq = 1'b0;
        #1;
        chk_all_zero("mid-reset");
        dq.delete(); gq.delete(); rq.delete();
        if (undo_e > edge_n) shadow[undo_cell] = undo_old;
        g_granted = 1'b0; g_free = 0; wait_n = 0; last_color = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        apply(1'b0, 0, 0);
    endtask

    always @(negedge clk) begin
        rsp_t r;
        ram_t m;
        if (!rst) begin
            if (dq.size() > 0 && dq[0].due == edge_n) begin
                r = dq.pop_front();
                chk("disp_valid", int'(dvalid), 1);
                chk("disp_color", int'(dcolor), int'(r.data));
                chk("disp_miss", int'(dmiss_o), int'(r.miss));
            end else chk("disp_valid idle", int'(dvalid), 0);
            if (gq.size() > 0 && gq[0].due == edge_n) begin
                r = gq.pop_front();
                chk("g_ack", int'(gack), 1);
                chk("g_rdata", int'(grdata), int'(r.data));
            end else chk("g_ack idle", int'(gack), 0);
            if (rq.size() > 0 && rq[0].e == edge_n) begin
                m = rq.pop_front();
                chk("ram_we", int'(ram_we), int'(m.we));
                if (m.chka) chk("ram_addr", int'(ram_addr), int'(m.addr));
                if (m.we) chk("ram_wdata", int'(ram_wdata), int'(m.wd));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] v;
        pl_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            v = CW'($urandom_range(0, 7));
            if (i >= 30 && i < 40) v = CW'((i - 30 + 1) % 8);
            if (i == 0) v = 3'd6;
            if (i >= ROWS * COLS) v = '0;
            else shadow[i] = v;
            pl_a = AW'(i); pl_d = v;
            @(posedge clk); #1;
        end
        pl_we = 1'b0;
        chk_all_zero("reset");
        rst = 1'b0;
        apply(1'b0, 0, 0);

        game_start(1'b0, 0, 0, 0, 1);
        repeat (8) tick(1'b0, 0, 0);
        wait_idle();

        for (int c = 0; c < 10; c++) tick(1'b1, 3, c);
        wait_idle();

        game_start(1'b1, 19, 9, 5, 0);
        for (int n = 0; n < 12; n++) tick(1'b1, 3, n % 10);
        wait_idle();
        game_start(1'b0, 19, 9, 0, 0);
        wait_idle();

        tick(1'b1, 20, 0);
        game_start(1'b1, 0, 10, 7, 0);
        wait_idle();
        game_start(1'b0, 0, 10, 0, 0);
        wait_idle();

        game_start(1'b1, 4, 4, 3, 0);
        tick(1'b0, 0, 0);
        tick(1'b1, 4, 4);
        wait_idle();

        game_start(1'b1, 5, 5, 7, 0);
        tick(1'b0, 0, 0);
        reset_mid();
        wait_idle();
        game_start(1'b0, 5, 5, 0, 0);
        wait_idle();

        for (int n = 0; n < 800; n++) begin
            if (!greq && !gi_pend && $urandom_range(0, 3) == 0)
                game_start(1'($urandom_range(0, 1)), int'($urandom_range(0, 21)),
                           int'($urandom_range(0, 11)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 1)));
            tick(1'($urandom_range(0, 9) < (n < 400 ? 5 : 9)),
                 int'($urandom_range(0, 21)), int'($urandom_range(0, 11)));
        end
        wait_idle();
        repeat (3) tick(1'b0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
